// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Destination-register scoreboard for a dual-issue pipeline. Tracks, per
// architectural register, whether a producer is in flight and which tag it
// carries. Writebacks retire an entry only when their tag matches the
// recorded producer. Four combinational source queries report RAW hazards.
//
// Ports
//   clk, rst                  rising-edge clock, async active-high reset
//   sb_i_iss{0,1}_*           issue slots (slot 0 older): valid, we, rd, tag
//   sb_i_wb{0,1}_*            writeback ports: valid, rd, tag
//   sb_i_q{0,1}_{rs,rt}       source addresses of issue slots 0/1
//   sb_o_q{0,1}_{rs,rt}_busy  source pending
//   sb_o_q{0,1}_{rs,rt}_tag   pending producer tag, 0 when not busy
//   sb_o_pending_cnt          number of busy registers in state
module reg_scoreboard #(
  parameter int AWIDTH = 5,
  parameter int TWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sb_i_iss0_valid,
  input  logic              sb_i_iss1_valid,
  input  logic              sb_i_iss0_we,
  input  logic              sb_i_iss1_we,
  input  logic [AWIDTH-1:0] sb_i_iss0_rd,
  input  logic [AWIDTH-1:0] sb_i_iss1_rd,
  input  logic [TWIDTH-1:0] sb_i_iss0_tag,
  input  logic [TWIDTH-1:0] sb_i_iss1_tag,
  input  logic              sb_i_wb0_valid,
  input  logic              sb_i_wb1_valid,
  input  logic [AWIDTH-1:0] sb_i_wb0_rd,
  input  logic [AWIDTH-1:0] sb_i_wb1_rd,
  input  logic [TWIDTH-1:0] sb_i_wb0_tag,
  input  logic [TWIDTH-1:0] sb_i_wb1_tag,
  input  logic [AWIDTH-1:0] sb_i_q0_rs,
  input  logic [AWIDTH-1:0] sb_i_q0_rt,
  input  logic [AWIDTH-1:0] sb_i_q1_rs,
  input  logic [AWIDTH-1:0] sb_i_q1_rt,
  output logic              sb_o_q0_rs_busy,
  output logic              sb_o_q0_rt_busy,
  output logic              sb_o_q1_rs_busy,
  output logic              sb_o_q1_rt_busy,
  output logic [TWIDTH-1:0] sb_o_q0_rs_tag,
  output logic [TWIDTH-1:0] sb_o_q0_rt_tag,
  output logic [TWIDTH-1:0] sb_o_q1_rs_tag,
  output logic [TWIDTH-1:0] sb_o_q1_rt_tag,
  output logic [AWIDTH:0]   sb_o_pending_cnt
);

  localparam int NREG = 1 << AWIDTH;

  logic [NREG-1:0]   busy_q, busy_d;
  logic [TWIDTH-1:0] tag_q [NREG];
  logic [TWIDTH-1:0] tag_d [NREG];

  logic iss0_hit, iss1_hit;
  assign iss0_hit = sb_i_iss0_valid && sb_i_iss0_we && (sb_i_iss0_rd != '0);
  assign iss1_hit = sb_i_iss1_valid && sb_i_iss1_we && (sb_i_iss1_rd != '0);

  // Writeback clears first, then issues overwrite: an issue to the same
  // register wins over a retiring writeback, and slot 1 (younger) wins
  // over slot 0.
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    for (int r = 1; r < NREG; r++) begin
      if (sb_i_wb0_valid && sb_i_wb0_rd == AWIDTH'(r) && busy_q[r] && tag_q[r] == sb_i_wb0_tag)
        busy_d[r] = 1'b0;
      if (sb_i_wb1_valid && sb_i_wb1_rd == AWIDTH'(r) && busy_q[r] && tag_q[r] == sb_i_wb1_tag)
        busy_d[r] = 1'b0;
      if (iss0_hit && sb_i_iss0_rd == AWIDTH'(r)) begin
        busy_d[r] = 1'b1;
        tag_d[r]  = sb_i_iss0_tag;
      end
      if (iss1_hit && sb_i_iss1_rd == AWIDTH'(r)) begin
        busy_d[r] = 1'b1;
        tag_d[r]  = sb_i_iss1_tag;
      end
    end
    busy_d[0] = 1'b0;
    tag_d[0]  = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      for (int r = 0; r < NREG; r++) tag_q[r] <= '0;
    end else begin
      busy_q <= busy_d;
      for (int r = 0; r < NREG; r++) tag_q[r] <= tag_d[r];
    end
  end

  // Queries 0,1 belong to slot 0; 2,3 to slot 1. Only slot-1 queries see
  // the same-cycle slot-0 issue, which overrides any writeback bypass.
  logic [AWIDTH-1:0] q_addr [4];
  logic              q_busy [4];
  logic [TWIDTH-1:0] q_tag  [4];

  assign q_addr[0] = sb_i_q0_rs;
  assign q_addr[1] = sb_i_q0_rt;
  assign q_addr[2] = sb_i_q1_rs;
  assign q_addr[3] = sb_i_q1_rt;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      q_busy[i] = busy_q[q_addr[i]];
      q_tag[i]  = tag_q[q_addr[i]];
      if (sb_i_wb0_valid && sb_i_wb0_rd == q_addr[i] && busy_q[q_addr[i]] &&
          sb_i_wb0_tag == tag_q[q_addr[i]])
        q_busy[i] = 1'b0;
      if (sb_i_wb1_valid && sb_i_wb1_rd == q_addr[i] && busy_q[q_addr[i]] &&
          sb_i_wb1_tag == tag_q[q_addr[i]])
        q_busy[i] = 1'b0;
      if (i >= 2 && iss0_hit && sb_i_iss0_rd == q_addr[i]) begin
        q_busy[i] = 1'b1;
        q_tag[i]  = sb_i_iss0_tag;
      end
      if (!q_busy[i] || q_addr[i] == '0 || rst) begin
        q_busy[i] = 1'b0;
        q_tag[i]  = '0;
      end
    end
  end

  assign sb_o_q0_rs_busy = q_busy[0];
  assign sb_o_q0_rt_busy = q_busy[1];
  assign sb_o_q1_rs_busy = q_busy[2];
  assign sb_o_q1_rt_busy = q_busy[3];
  assign sb_o_q0_rs_tag  = q_tag[0];
  assign sb_o_q0_rt_tag  = q_tag[1];
  assign sb_o_q1_rs_tag  = q_tag[2];
  assign sb_o_q1_rt_tag  = q_tag[3];

  always_comb begin
    sb_o_pending_cnt = '0;
    for (int r = 0; r < NREG; r++)
      sb_o_pending_cnt = sb_o_pending_cnt + (AWIDTH+1)'(busy_q[r]);
  end

endmodule
